// File: rtl/ram_init_loader.sv
// ram_init_loader: streams bytes from the storage source, packs them little-endian
// into 16-bit samples and writes NUM_WORDS of them into SRAM, then flags completion.
module ram_init_loader #(
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned NUM_WORDS = 65536
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              LOAD_MEM,
   input  logic [7:0]        Byte_in,
   input  logic              Byte_valid,
   output logic              Byte_ready,
   output logic [ADDR_W-1:0] Mem_addr,
   output logic [15:0]       Mem_wdata,
   output logic              Mem_we,
   input  logic              Mem_ack,
   output logic              RAM_INIT_DONE,
   output logic [ADDR_W:0]   Word_count
);

   localparam int unsigned CNT_W = ADDR_W + 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      GET_LO = 3'd1,
      GET_HI = 3'd2,
      WRITE  = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [7:0] low_byte;
   logic       byte_fire;
   logic       last_word;

   // State register
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; LOAD_MEM low only stalls the byte states, it never rewinds
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (LOAD_MEM) state_nxt = GET_LO;
         GET_LO:  if (byte_fire) state_nxt = GET_HI;
         GET_HI:  if (byte_fire) state_nxt = WRITE;
         WRITE:   if (Mem_ack) state_nxt = last_word ? DONE : GET_LO;
         DONE:    state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   // Combinational outputs: source handshake and final-word detect
   always_comb begin
      Byte_ready = 1'b0;
      if ((state == GET_LO) || (state == GET_HI)) begin
         Byte_ready = LOAD_MEM;
      end
      byte_fire = Byte_ready & Byte_valid;
      last_word = ((Word_count + CNT_W'(1)) == CNT_W'(NUM_WORDS));
   end

   // Datapath: byte packing, SRAM request, address/count progress and done flag
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         low_byte      <= 8'd0;
         Mem_addr      <= '0;
         Mem_wdata     <= 16'd0;
         Mem_we        <= 1'b0;
         RAM_INIT_DONE <= 1'b0;
         Word_count    <= '0;
      end else begin
         case (state)
            GET_LO: begin
               if (byte_fire) begin
                  low_byte <= Byte_in;
               end
            end
            GET_HI: begin
               if (byte_fire) begin
                  Mem_wdata <= {Byte_in, low_byte};
                  Mem_we    <= 1'b1;
               end
            end
            WRITE: begin
               if (Mem_ack) begin
                  Mem_we     <= 1'b0;
                  Word_count <= Word_count + CNT_W'(1);
                  if (last_word) begin
                     RAM_INIT_DONE <= 1'b1;
                  end else begin
                     Mem_addr <= Mem_addr + ADDR_W'(1);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/ram_init_loader.md
Name: ram_init_loader

Overview:
- Responder to the top-level control FSM's load request.
- While LOAD_MEM is high, pulls a byte stream from the storage source (SD/flash reader) over a valid/ready handshake.
- Packs byte pairs little-endian into 16-bit audio samples and writes them sequentially into on-board SRAM through a request/acknowledge write port.
- Raises RAM_INIT_DONE once NUM_WORDS samples are committed; the control FSM then enters play.

Parameters:
- ADDR_W, 16, SRAM word-address width.
- NUM_WORDS, 65536, samples to load; legal range 1..2^ADDR_W.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous active-low reset.
- LOAD_MEM  in  1  load request from control FSM; level-sensitive.
- Byte_in  in  8  source byte.
- Byte_valid  in  1  Byte_in valid.
- Byte_ready  out  1  loader accepts byte this cycle.
- Mem_addr  out  ADDR_W  SRAM word address.
- Mem_wdata  out  16  SRAM write data.
- Mem_we  out  1  write request; held until acked.
- Mem_ack  in  1  SRAM write complete; one-cycle pulse.
- RAM_INIT_DONE  out  1  all NUM_WORDS written; sticky until reset.
- Word_count  out  ADDR_W+1  samples committed so far (progress/debug).

Behaviour:
- Async reset (Reset_n low):
  - State IDLE.
  - All outputs 0; Mem_addr 0, Word_count 0.
  - Internal low-byte register 0.
- States: IDLE, GET_LO, GET_HI, WRITE, DONE.
- IDLE:
  - LOAD_MEM=1 -> GET_LO next cycle.
  - Otherwise stay.
- GET_LO:
  - Byte_ready = LOAD_MEM.
  - On Byte_valid & Byte_ready: latch Byte_in as low byte -> GET_HI.
- GET_HI:
  - Byte_ready = LOAD_MEM.
  - On handshake: Mem_wdata <= {Byte_in, low byte}; Mem_we <= 1 registered -> WRITE.
- Byte_ready is 0 in IDLE, WRITE and DONE. One byte accepted per handshake cycle, no buffering beyond the low-byte register.
- WRITE:
  - Mem_we, Mem_addr, Mem_wdata held stable until Mem_ack.
  - On Mem_ack: Mem_we <= 0; Word_count += 1.
  - If new count == NUM_WORDS -> DONE and RAM_INIT_DONE <= 1 in the same edge; Mem_addr stays at last address.
  - Else Mem_addr += 1 -> GET_LO.
- Mem_ack outside WRITE is ignored.
- DONE:
  - Terminal until reset.
  - RAM_INIT_DONE=1, Byte_ready=0, Mem_we=0.
  - LOAD_MEM ignored.
- LOAD_MEM deassert mid-load:
  - Pause only: Byte_ready forced 0 in GET_LO/GET_HI.
  - State, address, count and partial low byte retained.
  - Pending WRITE still completes on Mem_ack.
  - Reassert resumes with no data lost or duplicated.
- Minimum throughput: 2 byte cycles + 1 write issue cycle + ack latency per sample.
- Latency: RAM_INIT_DONE rises the cycle after the final Mem_ack edge.
- Address wrap: impossible by parameter bound. Word_count is ADDR_W+1 wide so NUM_WORDS = 2^ADDR_W is representable.
- Reset mid-operation: everything returns to reset values immediately. Any in-flight SRAM write is abandoned (Mem_we drops asynchronously).

Test Plan:
- Basic load, NUM_WORDS=4:
  - Stimulus: LOAD_MEM=1, bytes 01 02 03 04 05 06 07 08 streamed back-to-back, Mem_ack 2 cycles after each Mem_we.
  - Required: writes addr0=0x0201, 1=0x0403, 2=0x0605, 3=0x0807.
  - Required: RAM_INIT_DONE=1 after the 4th ack, Word_count=4.
- Source backpressure: Byte_valid toggles randomly -> identical SRAM contents; no byte accepted while Byte_valid=0.
- Slow SRAM:
  - Stimulus: Mem_ack delayed 10 cycles.
  - Required: Mem_we/addr/data stable for all 10 cycles, Byte_ready=0 throughout.
  - Required: stray Mem_ack pulses in GET_LO cause no count change.
- Pause: drop LOAD_MEM after the low byte of word 1 for 5 cycles, then reassert -> Byte_ready=0 during the pause; word 1 correct; no duplicate or missed byte.
- Reset mid-load: pull Reset_n low during WRITE of word 2 -> Mem_we=0, Word_count=0, Mem_addr=0 immediately; a fresh load restarts from addr 0.
- Post-done: after RAM_INIT_DONE, keep Byte_valid=1 and toggle LOAD_MEM -> Byte_ready stays 0, no further writes, RAM_INIT_DONE stays 1.
